mode_counter: RTL

Generalised loadable counter: N-bit up/down, programmable step, programmable modulo limit, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It is the next generation of the team's basic load/increment counter. It serves as the common timer/sequence-index primitive for datapath and control blocks. Single clock domain, fully synchronous.

---
 rtl/mode_counter_if.sv | 47 ++++
 rtl/mode_counter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mode_counter_if.sv
// Control and status bundle for mode_counter.
//   master: drives en, load_en, data_in, up_dn, step, limit, wrap_mode,
//           ovf_clr (and prescale when MODE_COUNTER_PRESCALE_EN is defined);
//           observes count_out, tc, ovf.
//   slave : the counter side (mirror of master).
// Optional feature macro: MODE_COUNTER_PRESCALE_EN adds PRE_W and prescale.
interface mode_counter_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned STEP_W = 4
`ifdef MODE_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned PRE_W  = 8
`endif
);

  logic              en;
  logic              load_en;
  logic [N-1:0]      data_in;
  logic              up_dn;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      limit;
  logic              wrap_mode;
  logic              ovf_clr;
`ifdef MODE_COUNTER_PRESCALE_EN
  logic [PRE_W-1:0]  prescale;
`endif
  logic [N-1:0]      count_out;
  logic              tc;
  logic              ovf;

  modport master (
    output en, load_en, data_in, up_dn, step, limit, wrap_mode, ovf_clr,
`ifdef MODE_COUNTER_PRESCALE_EN
    output prescale,
`endif
    input  count_out, tc, ovf
  );

  modport slave (
    input  en, load_en, data_in, up_dn, step, limit, wrap_mode, ovf_clr,
`ifdef MODE_COUNTER_PRESCALE_EN
    input  prescale,
`endif
    output count_out, tc, ovf
  );

endinterface

// File: rtl/mode_counter.sv
// mode_counter: loadable N-bit up/down counter with programmable step,
// modulo limit (count range 0..limit), wrap or saturate mode, registered
// terminal-count pulse and sticky overflow flag.
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset
//   bus     - mode_counter_if.slave (controls in, count_out/tc/ovf out)
// Optional feature macro: MODE_COUNTER_PRESCALE_EN
//   When defined, adds PRE_W and bus.prescale; the counter steps once per
//   prescale+1 enabled cycles. When undefined it steps on every en cycle.
module mode_counter #(
  parameter int unsigned N      = 8,
  parameter int unsigned STEP_W = 4
`ifdef MODE_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned PRE_W  = 8
`endif
) (
  input logic          clk,
  input logic          reset_n,
  mode_counter_if.slave bus
);

  localparam int unsigned W1 = N + 1;

  logic [N-1:0]  cnt_q, cnt_d;
  logic          tc_q, tc_d;
  logic          ovf_q, ovf_d;
  logic          evt;
  logic          adv;
  logic [W1-1:0] cnt_ext, step_ext, lim_ext, mod_ext, sum, wrapped, down_base;

`ifdef MODE_COUNTER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler: >= keeps it from running away if prescale is lowered mid-period.
  always_comb begin
    pre_d = pre_q;
    adv   = 1'b0;
    if (bus.load_en) begin
      pre_d = '0;
    end else if (bus.en) begin
      adv   = (pre_q >= bus.prescale);
      pre_d = adv ? '0 : pre_q + PRE_W'(1);
    end
  end
`else
  assign adv = 1'b1;
`endif

  // Next-state count, boundary event detection and flag updates.
  always_comb begin
    cnt_ext   = {1'b0, cnt_q};
    step_ext  = W1'(bus.step);
    lim_ext   = {1'b0, bus.limit};
    mod_ext   = lim_ext + W1'(1);
    sum       = cnt_ext + step_ext;
    wrapped   = sum - mod_ext;
    down_base = cnt_ext + mod_ext;
    cnt_d     = cnt_q;
    evt       = 1'b0;

    if (bus.load_en) begin
      cnt_d = (bus.data_in > bus.limit) ? bus.limit : bus.data_in;
    end else if (bus.en && adv) begin
      if (cnt_q > bus.limit) begin
        // Count stranded above a lowered limit: always a boundary event.
        evt   = 1'b1;
        cnt_d = (bus.up_dn && bus.wrap_mode) ? '0 : bus.limit;
      end else if (bus.up_dn) begin
        if (sum <= lim_ext) begin
          cnt_d = N'(sum);
        end else begin
          evt = 1'b1;
          if (bus.wrap_mode) begin
            // step > limit+1 can leave the wrapped value still out of range.
            cnt_d = (wrapped > lim_ext) ? bus.limit : N'(wrapped);
          end else begin
            cnt_d = bus.limit;
          end
        end
      end else begin
        if (step_ext <= cnt_ext) begin
          cnt_d = N'(cnt_ext - step_ext);
        end else begin
          evt = 1'b1;
          if (bus.wrap_mode) begin
            // Result is < limit+1 whenever non-negative, so it fits in N bits.
            cnt_d = (step_ext > down_base) ? '0 : N'(down_base - step_ext);
          end else begin
            cnt_d = '0;
          end
        end
      end
    end

    tc_d  = evt;
    ovf_d = evt | (ovf_q & ~bus.ovf_clr);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
`ifdef MODE_COUNTER_PRESCALE_EN
      pre_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
`ifdef MODE_COUNTER_PRESCALE_EN
      pre_q <= pre_d;
`endif
    end
  end

  assign bus.count_out = cnt_q;
  assign bus.tc        = tc_q;
  assign bus.ovf       = ovf_q;

endmodule
